// File: rtl/concat_pkg.sv
// Shared width defaults for the 26+6 -> 32 bit concatenation block.
package concat_pkg;

  localparam int unsigned MAIN_W_DEF = 26;
  localparam int unsigned CONC_W_DEF = 6;
  localparam int unsigned OUT_W_DEF  = 32;

endpackage

// File: rtl/concat_pipe_reg.sv
// Single pipeline register stage with load-enable, hold and a valid flag.
// Asynchronous active-high reset clears both data and valid.
module concat_pipe_reg #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             hold_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o,
  output logic             valid_o
);

  logic [Width-1:0] data_d, data_q;
  logic             valid_d, valid_q;

  // Hold wins over load; without load the data is kept but valid drops.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (!hold_i) begin
      valid_d = load_i;
      if (load_i) begin
        data_d = d_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign q_o     = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/concatenate_26_to_32_bit.sv
// Builds o = {in_conc, in_main} combinationally plus a one-stage registered copy.
// Define CONCAT_PARITY_EN to add parity_q, the XOR reduction of the captured word.
module concatenate_26_to_32_bit
  import concat_pkg::*;
#(
  parameter int unsigned MAIN_W = MAIN_W_DEF,
  parameter int unsigned CONC_W = CONC_W_DEF,
  parameter int unsigned OUT_W  = OUT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              hold,
  input  logic [MAIN_W-1:0] in_main,
  input  logic [CONC_W-1:0] in_conc,
  output logic [OUT_W-1:0]  o,
  output logic [OUT_W-1:0]  o_q,
`ifdef CONCAT_PARITY_EN
  output logic              parity_q,
`endif
  output logic              out_valid
);

  if (MAIN_W + CONC_W != OUT_W) begin : g_width_err
    $error("concatenate_26_to_32_bit: MAIN_W + CONC_W must equal OUT_W");
  end

  assign o = {in_conc, in_main};

`ifdef CONCAT_PARITY_EN
  // Parity rides in the top bit of the stage so it follows o_q exactly.
  logic [OUT_W:0] stage_d, stage_q;

  assign stage_d  = {^o, o};
  assign o_q      = stage_q[OUT_W-1:0];
  assign parity_q = stage_q[OUT_W];

  concat_pipe_reg #(
    .Width (OUT_W + 1)
  ) u_pipe_reg (
    .clk_i   (clk),
    .rst_i   (rst),
    .load_i  (in_valid),
    .hold_i  (hold),
    .d_i     (stage_d),
    .q_o     (stage_q),
    .valid_o (out_valid)
  );
`else
  concat_pipe_reg #(
    .Width (OUT_W)
  ) u_pipe_reg (
    .clk_i   (clk),
    .rst_i   (rst),
    .load_i  (in_valid),
    .hold_i  (hold),
    .d_i     (o),
    .q_o     (o_q),
    .valid_o (out_valid)
  );
`endif

endmodule

// File: tb/tb_concatenate_26_to_32_bit.sv
// Bench for concatenate_26_to_32_bit: directed steps plus random traffic against a reference model.
module tb_concatenate_26_to_32_bit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        hold;
  logic [25:0] in_main;
  logic [5:0]  in_conc;
  logic [31:0] o;
  logic [31:0] o_q;
  logic        parity_q;
  logic        out_valid;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q;
  logic        exp_valid;

  concatenate_26_to_32_bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .hold      (hold),
    .in_main   (in_main),
    .in_conc   (in_conc),
    .o         (o),
    .o_q       (o_q),
`ifdef CONCAT_PARITY_EN
    .parity_q  (parity_q),
`endif
    .out_valid (out_valid)
  );

`ifndef CONCAT_PARITY_EN
  assign parity_q = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference value: in_conc weighted above the 26 low bits.
  function automatic logic [31:0] ref_word(input logic [25:0] m, input logic [5:0] c);
    return (32'(c) * 32'd67108864) + 32'(m);
  endfunction

  task automatic model_edge();
    if (rst) begin
      exp_q     = '0;
      exp_valid = 1'b0;
    end else if (!hold) begin
      if (in_valid) exp_q = ref_word(in_main, in_conc);
      exp_valid = in_valid;
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_oq"}, o_q, exp_q);
    check({tag, "_vld"}, 32'(out_valid), 32'(exp_valid));
`ifdef CONCAT_PARITY_EN
    check({tag, "_par"}, 32'(parity_q), 32'($countones(exp_q) % 2));
`endif
  endtask

  task automatic drive(input logic [25:0] m, input logic [5:0] c, input logic v, input logic h,
                       input string tag);
    @(negedge clk);
    in_main  = m;
    in_conc  = c;
    in_valid = v;
    hold     = h;
    #1 check({tag, "_o"}, o, ref_word(m, c));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1 check_regs(tag);
  endtask

  initial begin
    logic [31:0] bit_word;

    rst = 1'b1; in_valid = 1'b0; hold = 1'b0; in_main = '0; in_conc = '0;
    exp_q = '0; exp_valid = 1'b0;
    #1;
    check("reset_o", o, 32'h0000_0000);
    check_regs("reset");
    step("reset_held");

    @(negedge clk);
    rst = 1'b0;
    drive(26'h3FF_FFFD, 6'h3F, 1'b1, 1'b0, "t2");
    check("t2_o_const", o, 32'hFFFF_FFFD);
    step("t2");
    check("t2_oq_const", o_q, 32'hFFFF_FFFD);
`ifdef CONCAT_PARITY_EN
    check("t2_par_const", 32'(parity_q), 32'd1);
`endif

    drive(26'h3FF_FFFC, 6'h00, 1'b1, 1'b0, "t3");
    check("t3_o_const", o, 32'h03FF_FFFC);
    step("t3");

    drive(26'h000_0001, 6'h20, 1'b1, 1'b1, "t4");
    check("t4_o_const", o, 32'h8000_0001);
    step("t4_hold");
    check("t4_oq_const", o_q, 32'h03FF_FFFC);

    drive(26'h155_5555, 6'h15, 1'b0, 1'b0, "idle");
    step("idle");

    // Asynchronous reset between edges, then release with data waiting.
    drive(26'h2AA_AAAA, 6'h2A, 1'b1, 1'b0, "pre_rst");
    step("pre_rst");
    #2 rst = 1'b1;
    exp_q = '0; exp_valid = 1'b0;
    #1 check_regs("async_rst");
    drive(26'h123_4567, 6'h11, 1'b1, 1'b0, "rst_rel");
    rst = 1'b0;
    step("rst_rel");

    for (int i = 0; i < 32; i++) begin
      bit_word = 32'd1 << i;
      drive(bit_word[25:0], bit_word[31:26], 1'b1, 1'b0, $sformatf("walk%0d", i));
      check($sformatf("walk%0d_o_bit", i), o, bit_word);
      step($sformatf("walk%0d", i));
      check($sformatf("walk%0d_oq_bit", i), o_q, bit_word);
    end

    for (int i = 0; i < 60; i++) begin
      drive(26'($urandom()), 6'($urandom()), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 4) == 0), $sformatf("rnd%0d", i));
      step($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
